video_timing_scanout: RTL and testbench
=======================================

Name: video_timing_scanout

Overview:
- Generates raster timing for the video path and turns the returned pixel colour into physical display signals.
- Drives the video controller's timing inputs: hblank, vblank, pos_x and pos_y.
- Takes the controller's registered palette colour (o_video_rdata) and delays sync/DE to match its pipeline latency.
- Emits HSYNC, VSYNC, DE and 8-bit RGB at one pixel per clock; i_clock is the pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of o_vga_hsync
- VSYNC_POL, 0, asserted level of o_vga_vsync
- PIXEL_LATENCY, 3, clocks from pos_x/pos_y to valid i_video_rdata (legal range 1..8)

Ports:
- i_clock  in  1  pixel clock; single clock domain
- i_reset_n  in  1  asynchronous, active-low reset
- o_video_hblank  out  1  1 while h_count < H_ACTIVE (visible-high, matching controller semantics)
- o_video_vblank  out  1  1 while v_count < V_ACTIVE (visible-high)
- o_video_pos_x  out  11  current h_count
- o_video_pos_y  out  11  current v_count
- i_video_rdata  in  32  {8'h00, R[23:16], G[15:8], B[7:0]} from the controller
- o_vga_hsync  out  1  horizontal sync, delay-aligned
- o_vga_vsync  out  1  vertical sync, delay-aligned
- o_vga_de  out  1  display enable, delay-aligned
- o_vga_r  out  8  red
- o_vga_g  out  8  green
- o_vga_b  out  8  blue
- o_frame_start  out  1  one-clock pulse when (h,v) becomes (0,0)
- o_frame_counter  out  32  frames started since reset

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK.
  - Elaboration error if either total exceeds 2048.
  - Elaboration error if PIXEL_LATENCY is outside 1..8.
- Counters:
  - h_count increments every clock and wraps H_TOTAL-1 -> 0.
  - v_count increments on every h wrap and wraps V_TOTAL-1 -> 0.
- Reset (asynchronous, i_reset_n=0):
  - h_count = H_TOTAL-1, v_count = V_TOTAL-1.
  - o_video_hblank = 0, o_video_vblank = 0, pos_x/pos_y = 0.
  - Sync outputs at their inactive level (~HSYNC_POL / ~VSYNC_POL), o_vga_de = 0, RGB = 0.
  - Delay lines cleared to the inactive level.
  - o_frame_start = 0, o_frame_counter = 0.
- First clock after release: counters become (0,0), o_frame_start = 1, o_frame_counter = 1.
- Timing outputs are registered and always correspond to the counter value held in the same cycle.
- Raw sync/DE:
  - hs_raw = 1 for H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC.
  - vs_raw = 1 for V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC; vsync changes only at h=0.
  - de_raw = hblank & vblank.
- Alignment: hs_raw, vs_raw and de_raw each pass through a PIXEL_LATENCY-deep shift register. The tap feeds:
  - o_vga_hsync = tap ? HSYNC_POL : ~HSYNC_POL
  - o_vga_vsync = tap ? VSYNC_POL : ~VSYNC_POL
  - o_vga_de = tap
- RGB, registered in the same stage as the tap:
  - delayed DE = 1: r/g/b = i_video_rdata[23:16] / [15:8] / [7:0].
  - delayed DE = 0: r/g/b = 0, so blanking always outputs black.
  - Bits [31:24] are ignored.
- Controller interface (edges seen by the controller):
  - Falling edge of hblank while vblank = 1 happens at h = H_ACTIVE on visible lines. This triggers the next line fetch.
  - Falling edge of vblank happens at (0, V_ACTIVE). This is the frame-end reset point.
- o_frame_counter increments by 1 with each o_frame_start and wraps at 2^32.
- Reset mid-frame: all state returns to reset values immediately. No partial sync pulse persists past reset assertion.

Test Plan:
- Reset release, default params -> o_frame_start=1 exactly 1 clock after release with pos=(0,0), hblank=1, vblank=1; o_vga_de rises 3 clocks later.
- Run one line -> hblank falls at h=640. o_vga_hsync is low for clocks h=656..751 (delayed +3). pos_x wraps 799->0 and pos_y increments.
- Run a full frame -> vblank falls at (0,480). vsync is low on lines 490-491. o_frame_start repeats every 800*525=420000 clocks and o_frame_counter=2.
- Drive i_video_rdata=32'hAB123456 constantly -> visible pixels give r=12, g=34, b=56. Blank periods give 0/0/0 with de=0.
- Drive i_video_rdata = pos_x delayed by 3 -> o_vga_r/g/b track the x low bits with no off-by-one at h=0 and h=639.
- Assert i_reset_n low mid-line for 5 clocks -> outputs take reset values asynchronously. After release the frame restarts at (0,0) and o_frame_counter=1.
- PIXEL_LATENCY=1, H_ACTIVE=8, H_FRONT=H_SYNC=H_BACK=2, V_ACTIVE=4, V_FRONT=V_SYNC=V_BACK=1 -> H_TOTAL=14, V_TOTAL=7, frame period 98 clocks, de aligned 1 clock after hblank.

Source files
------------

// File: rtl/video_timing_scanout.sv
// Raster timing generator and pixel scanout for the video path.
// Ports: i_clock/i_reset_n, controller timing (hblank/vblank/pos), i_video_rdata,
//   VGA hsync/vsync/de/rgb, frame start pulse and frame counter.
module video_timing_scanout #(
    parameter int   H_ACTIVE      = 640,
    parameter int   H_FRONT       = 16,
    parameter int   H_SYNC        = 96,
    parameter int   H_BACK        = 48,
    parameter int   V_ACTIVE      = 480,
    parameter int   V_FRONT       = 10,
    parameter int   V_SYNC        = 2,
    parameter int   V_BACK        = 33,
    parameter logic HSYNC_POL     = 1'b0,
    parameter logic VSYNC_POL     = 1'b0,
    parameter int   PIXEL_LATENCY = 3
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    output logic        o_video_hblank,
    output logic        o_video_vblank,
    output logic [10:0] o_video_pos_x,
    output logic [10:0] o_video_pos_y,
    input  logic [31:0] i_video_rdata,
    output logic        o_vga_hsync,
    output logic        o_vga_vsync,
    output logic        o_vga_de,
    output logic [7:0]  o_vga_r,
    output logic [7:0]  o_vga_g,
    output logic [7:0]  o_vga_b,
    output logic        o_frame_start,
    output logic [31:0] o_frame_counter
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // 12-bit bounds so a sync edge at exactly 2048 does not truncate.
    localparam logic [11:0] H_VIS  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_ON  = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HS_OFF = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] V_VIS  = 12'(V_ACTIVE);
    localparam logic [11:0] VS_ON  = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] VS_OFF = 12'(V_ACTIVE + V_FRONT + V_SYNC);

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
        $error("video_timing_scanout: raster total exceeds 2048");
    end

    if (PIXEL_LATENCY < 1 || PIXEL_LATENCY > 8) begin : g_bad_latency
        $error("video_timing_scanout: PIXEL_LATENCY must be 1..8");
    end

    logic [10:0] h_count;
    logic [10:0] v_count;
    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        h_wrap;
    logic        v_wrap;
    logic        at_origin;
    logic        hblank_next;
    logic        vblank_next;
    logic        hs_next;
    logic        vs_next;

    logic        hs_raw;
    logic        vs_raw;
    logic        de_raw;

    always_comb begin
        h_wrap = (h_count == H_LAST);
        v_wrap = (v_count == V_LAST);
        h_next = h_wrap ? 11'd0 : h_count + 11'd1;
        v_next = v_count;
        if (h_wrap) begin
            v_next = v_wrap ? 11'd0 : v_count + 11'd1;
        end
    end

    // Everything is decoded from the next counter value so the registered
    // outputs line up with the counter held in the same cycle.
    assign at_origin   = (h_next == 11'd0) && (v_next == 11'd0);
    assign hblank_next = ({1'b0, h_next} < H_VIS);
    assign vblank_next = ({1'b0, v_next} < V_VIS);
    assign hs_next     = ({1'b0, h_next} >= HS_ON) && ({1'b0, h_next} < HS_OFF);
    assign vs_next     = ({1'b0, v_next} >= VS_ON) && ({1'b0, v_next} < VS_OFF);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            h_count         <= H_LAST;
            v_count         <= V_LAST;
            o_video_hblank  <= 1'b0;
            o_video_vblank  <= 1'b0;
            o_video_pos_x   <= 11'd0;
            o_video_pos_y   <= 11'd0;
            hs_raw          <= 1'b0;
            vs_raw          <= 1'b0;
            o_frame_start   <= 1'b0;
            o_frame_counter <= 32'd0;
        end else begin
            h_count        <= h_next;
            v_count        <= v_next;
            o_video_hblank <= hblank_next;
            o_video_vblank <= vblank_next;
            o_video_pos_x  <= h_next;
            o_video_pos_y  <= v_next;
            hs_raw         <= hs_next;
            vs_raw         <= vs_next;
            o_frame_start  <= at_origin;
            if (at_origin) begin
                o_frame_counter <= o_frame_counter + 32'd1;
            end
        end
    end

    assign de_raw = o_video_hblank & o_video_vblank;

    // Chains carry the raw (active-high) flags; index 0 is the undelayed
    // value, index PIXEL_LATENCY is the tap that drives the pins.
    logic [PIXEL_LATENCY-1:0] hs_q;
    logic [PIXEL_LATENCY-1:0] vs_q;
    logic [PIXEL_LATENCY-1:0] de_q;
    logic [PIXEL_LATENCY:0]   hs_chain;
    logic [PIXEL_LATENCY:0]   vs_chain;
    logic [PIXEL_LATENCY:0]   de_chain;

    assign hs_chain = {hs_q, hs_raw};
    assign vs_chain = {vs_q, vs_raw};
    assign de_chain = {de_q, de_raw};

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hs_q <= '0;
            vs_q <= '0;
            de_q <= '0;
        end else begin
            hs_q <= hs_chain[PIXEL_LATENCY-1:0];
            vs_q <= vs_chain[PIXEL_LATENCY-1:0];
            de_q <= de_chain[PIXEL_LATENCY-1:0];
        end
    end

    // Colour is captured on the same edge that moves DE into the tap, so
    // blanking is forced to black regardless of what the controller sends.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_vga_r <= 8'd0;
            o_vga_g <= 8'd0;
            o_vga_b <= 8'd0;
        end else if (de_chain[PIXEL_LATENCY-1]) begin
            o_vga_r <= i_video_rdata[23:16];
            o_vga_g <= i_video_rdata[15:8];
            o_vga_b <= i_video_rdata[7:0];
        end else begin
            o_vga_r <= 8'd0;
            o_vga_g <= 8'd0;
            o_vga_b <= 8'd0;
        end
    end

    logic [7:0] unused_rdata_hi;
    assign unused_rdata_hi = i_video_rdata[31:24];

    assign o_vga_hsync = hs_q[PIXEL_LATENCY-1] ? HSYNC_POL : ~HSYNC_POL;
    assign o_vga_vsync = vs_q[PIXEL_LATENCY-1] ? VSYNC_POL : ~VSYNC_POL;
    assign o_vga_de    = de_q[PIXEL_LATENCY-1];

endmodule

// File: tb/tb_video_timing_scanout.sv
// Directed bench for video_timing_scanout on a 14x7 raster.
// Instance a uses PIXEL_LATENCY=3, instance b uses PIXEL_LATENCY=1.
module tb_video_timing_scanout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        track;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [31:0] rdata;

    logic        hblank, vblank, hsync, vsync, de, fstart;
    logic [10:0] pos_x, pos_y;
    logic [7:0]  r, g, b;
    logic [31:0] fcnt;

    logic        hblank2, vblank2, hsync2, vsync2, de2, fstart2;
    logic [10:0] pos_x2, pos_y2;
    logic [7:0]  r2, g2, b2;
    logic [31:0] fcnt2;

    int checks = 0;
    int errors = 0;
    int n = 0;

    always #5 clk = ~clk;

    // Colour source that makes the pixel for pos_x arrive on the
    // PIXEL_LATENCY-th edge (3) after pos_x was presented.
    always @(posedge clk) begin
        p1 <= pos_x[7:0];
        p2 <= p1;
    end

    assign rdata = track ? {8'hFF, p2, ~p2, p2 ^ 8'h5A} : 32'hAB123456;

    video_timing_scanout #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIXEL_LATENCY(3)
    ) dut_a (
        .i_clock(clk), .i_reset_n(rst_n),
        .o_video_hblank(hblank), .o_video_vblank(vblank),
        .o_video_pos_x(pos_x), .o_video_pos_y(pos_y),
        .i_video_rdata(rdata),
        .o_vga_hsync(hsync), .o_vga_vsync(vsync), .o_vga_de(de),
        .o_vga_r(r), .o_vga_g(g), .o_vga_b(b),
        .o_frame_start(fstart), .o_frame_counter(fcnt)
    );

    video_timing_scanout #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIXEL_LATENCY(1)
    ) dut_b (
        .i_clock(clk), .i_reset_n(rst_n),
        .o_video_hblank(hblank2), .o_video_vblank(vblank2),
        .o_video_pos_x(pos_x2), .o_video_pos_y(pos_y2),
        .i_video_rdata(rdata),
        .o_vga_hsync(hsync2), .o_vga_vsync(vsync2), .o_vga_de(de2),
        .o_vga_r(r2), .o_vga_g(g2), .o_vga_b(b2),
        .o_frame_start(fstart2), .o_frame_counter(fcnt2)
    );

    // m = number of clock edges since reset release; m=1 is (0,0).
    function automatic int hh(int m);
        return (m - 1) % 14;
    endfunction

    function automatic int vv(int m);
        return ((m - 1) / 14) % 7;
    endfunction

    function automatic logic de_raw(int m);
        return (m >= 1) && (hh(m) < 8) && (vv(m) < 4);
    endfunction

    function automatic logic hs_raw(int m);
        return (m >= 1) && (hh(m) >= 10) && (hh(m) < 12);
    endfunction

    function automatic logic vs_raw(int m);
        return (m >= 1) && (vv(m) == 5);
    endfunction

    function automatic logic [23:0] exp_tim(int m);
        if (m < 1) return 24'd0;
        return {hh(m) < 8, vv(m) < 4, 11'(hh(m)), 11'(vv(m))};
    endfunction

    function automatic logic [26:0] exp_pix(int m, int lat, logic trk);
        int k;
        logic [7:0] x;
        logic [23:0] c;
        k = m - lat;
        x = (k >= 1) ? 8'(hh(k)) : 8'd0;
        c = trk ? {x, ~x, x ^ 8'h5A} : 24'h123456;
        if (!de_raw(k)) c = 24'd0;
        return {~hs_raw(k), ~vs_raw(k), de_raw(k), c};
    endfunction

    function automatic logic [32:0] exp_frm(int m);
        if (m < 1) return 33'd0;
        return {((m - 1) % 98) == 0, 32'((m - 1) / 98 + 1)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic test_reset();
        checks++;
        if ({hblank, vblank, pos_x, pos_y} !== 24'd0) begin
            errors++;
            $display("FAIL reset_timing got %0h want 0",
                     {hblank, vblank, pos_x, pos_y});
        end
        checks++;
        if ({hsync, vsync, de, r, g, b} !== {3'b110, 24'd0}) begin
            errors++;
            $display("FAIL reset_pixel got %0h want %0h",
                     {hsync, vsync, de, r, g, b}, {3'b110, 24'd0});
        end
        checks++;
        if ({fstart, fcnt} !== 33'd0) begin
            errors++;
            $display("FAIL reset_frame got %0h want 0", {fstart, fcnt});
        end
        checks++;
        if ({hsync2, vsync2, de2} !== 3'b110) begin
            errors++;
            $display("FAIL reset_sync_b got %0b want 110",
                     {hsync2, vsync2, de2});
        end
    endtask

    task automatic test_first_clock();
        step();
        checks++;
        if ({fstart, fcnt, pos_x, pos_y} !== {1'b1, 32'd1, 22'd0}) begin
            errors++;
            $display("FAIL first_frame got fs=%0b cnt=%0d x=%0d y=%0d want 1 1 0 0",
                     fstart, fcnt, pos_x, pos_y);
        end
        checks++;
        if ({hblank, vblank, de} !== 3'b110) begin
            errors++;
            $display("FAIL first_blank got %0b want 110", {hblank, vblank, de});
        end
        step();
        checks++;
        if ({fstart, de, de2, r2} !== {3'b001, 8'h12}) begin
            errors++;
            $display("FAIL second_clock got %0h want %0h",
                     {fstart, de, de2, r2}, {3'b001, 8'h12});
        end
        step();
        checks++;
        if (de !== 1'b0) begin
            errors++;
            $display("FAIL de_early got %0b want 0", de);
        end
        step();
        checks++;
        if ({de, r, g, b} !== {1'b1, 24'h123456}) begin
            errors++;
            $display("FAIL de_rise got %0h want %0h",
                     {de, r, g, b}, {1'b1, 24'h123456});
        end
    endtask

    task automatic test_line();
        while (n < 8) step();
        checks++;
        if ({hblank, pos_x} !== {1'b1, 11'd7}) begin
            errors++;
            $display("FAIL hblank_last got %0b/%0d want 1/7", hblank, pos_x);
        end
        step();
        checks++;
        if ({hblank, vblank, pos_x, de2} !== {2'b01, 11'd8, 1'b1}) begin
            errors++;
            $display("FAIL hblank_fall got %0h want %0h",
                     {hblank, vblank, pos_x, de2}, {2'b01, 11'd8, 1'b1});
        end
        step();
        checks++;
        if (de2 !== 1'b0) begin
            errors++;
            $display("FAIL de_b_fall got %0b want 0", de2);
        end
        while (n < 13) step();
        checks++;
        if (hsync !== 1'b1) begin
            errors++;
            $display("FAIL hsync_pre got %0b want 1", hsync);
        end
        step();
        checks++;
        if ({hsync, pos_x, pos_y} !== {1'b0, 11'd13, 11'd0}) begin
            errors++;
            $display("FAIL hsync_on got %0b x=%0d y=%0d want 0 13 0",
                     hsync, pos_x, pos_y);
        end
        step();
        checks++;
        if ({hsync, pos_x, pos_y} !== {1'b0, 11'd0, 11'd1}) begin
            errors++;
            $display("FAIL line_wrap got %0b x=%0d y=%0d want 0 0 1",
                     hsync, pos_x, pos_y);
        end
        step();
        checks++;
        if (hsync !== 1'b1) begin
            errors++;
            $display("FAIL hsync_off got %0b want 1", hsync);
        end
    endtask

    task automatic test_frame();
        while (n < 210) begin
            step();
            checks++;
            if ({hblank, vblank, pos_x, pos_y} !== exp_tim(n)) begin
                errors++;
                $display("FAIL frame_tim_a n=%0d got %0h want %0h", n,
                         {hblank, vblank, pos_x, pos_y}, exp_tim(n));
            end
            checks++;
            if ({hsync, vsync, de, r, g, b} !== exp_pix(n, 3, 1'b0)) begin
                errors++;
                $display("FAIL frame_pix_a n=%0d got %0h want %0h", n,
                         {hsync, vsync, de, r, g, b}, exp_pix(n, 3, 1'b0));
            end
            checks++;
            if ({fstart, fcnt} !== exp_frm(n)) begin
                errors++;
                $display("FAIL frame_cnt_a n=%0d got %0h want %0h", n,
                         {fstart, fcnt}, exp_frm(n));
            end
            checks++;
            if ({hblank2, vblank2, pos_x2, pos_y2} !== exp_tim(n)) begin
                errors++;
                $display("FAIL frame_tim_b n=%0d got %0h want %0h", n,
                         {hblank2, vblank2, pos_x2, pos_y2}, exp_tim(n));
            end
            checks++;
            if ({hsync2, vsync2, de2, r2, g2, b2} !== exp_pix(n, 1, 1'b0)) begin
                errors++;
                $display("FAIL frame_pix_b n=%0d got %0h want %0h", n,
                         {hsync2, vsync2, de2, r2, g2, b2}, exp_pix(n, 1, 1'b0));
            end
            checks++;
            if ({fstart2, fcnt2} !== exp_frm(n)) begin
                errors++;
                $display("FAIL frame_cnt_b n=%0d got %0h want %0h", n,
                         {fstart2, fcnt2}, exp_frm(n));
            end
            if (n == 57) begin
                checks++;
                if ({vblank, pos_x, pos_y} !== {1'b0, 11'd0, 11'd4}) begin
                    errors++;
                    $display("FAIL vblank_fall got %0b x=%0d y=%0d want 0 0 4",
                             vblank, pos_x, pos_y);
                end
            end
            if (n == 73 || n == 88) begin
                checks++;
                if (vsync !== 1'b1) begin
                    errors++;
                    $display("FAIL vsync_idle n=%0d got %0b want 1", n, vsync);
                end
            end
            if (n == 74 || n == 87) begin
                checks++;
                if (vsync !== 1'b0) begin
                    errors++;
                    $display("FAIL vsync_on n=%0d got %0b want 0", n, vsync);
                end
            end
            if (n == 99) begin
                checks++;
                if ({fstart, fcnt, fstart2} !== {1'b1, 32'd2, 1'b1}) begin
                    errors++;
                    $display("FAIL second_frame got fs=%0b cnt=%0d want 1 2",
                             fstart, fcnt);
                end
            end
        end
    endtask

    task automatic test_pixel_track();
        track = 1'b1;
        repeat (28) begin
            step();
            checks++;
            if ({hsync, vsync, de, r, g, b} !== exp_pix(n, 3, 1'b1)) begin
                errors++;
                $display("FAIL track_pix n=%0d got %0h want %0h", n,
                         {hsync, vsync, de, r, g, b}, exp_pix(n, 3, 1'b1));
            end
            if (de_raw(n - 3) && (hh(n - 3) == 0 || hh(n - 3) == 7)) begin
                checks++;
                if (r !== 8'(hh(n - 3))) begin
                    errors++;
                    $display("FAIL track_edge n=%0d got r=%0d want %0d",
                             n, r, hh(n - 3));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        k = 0;
        while (hsync !== 1'b0 && k < 20) begin
            step();
            k++;
        end
        checks++;
        if (hsync !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait got hsync=%0b want 0", hsync);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({hsync, vsync, de, r, g, b} !== {3'b110, 24'd0}) begin
            errors++;
            $display("FAIL mid_async got %0h want %0h",
                     {hsync, vsync, de, r, g, b}, {3'b110, 24'd0});
        end
        checks++;
        if ({hblank, vblank, pos_x, pos_y, fstart, fcnt} !== 57'd0) begin
            errors++;
            $display("FAIL mid_state got %0h want 0",
                     {hblank, vblank, pos_x, pos_y, fstart, fcnt});
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({hsync, de, pos_x, fcnt} !== {2'b10, 11'd0, 32'd0}) begin
            errors++;
            $display("FAIL mid_hold got %0h want %0h",
                     {hsync, de, pos_x, fcnt}, {2'b10, 11'd0, 32'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        step();
        checks++;
        if ({fstart, fcnt, pos_x, pos_y} !== {1'b1, 32'd1, 22'd0}) begin
            errors++;
            $display("FAIL restart got fs=%0b cnt=%0d x=%0d y=%0d want 1 1 0 0",
                     fstart, fcnt, pos_x, pos_y);
        end
        while (n < 4) step();
        checks++;
        if ({de, r, g, b} !== {1'b1, 24'h00FF5A}) begin
            errors++;
            $display("FAIL restart_pix got %0h want %0h",
                     {de, r, g, b}, {1'b1, 24'h00FF5A});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        track = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        test_first_clock();
        test_line();
        test_frame();
        test_pixel_track();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
